sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter for a single-port async SRAM.
// Ports: req0/req1 valid-ready access channels, rsp read-data pulse, busy, sram_* pins + shared data bus.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  typedef enum logic [2:0] {
    IDLE, WR, RD1, RD2, RESP
  } state_t;

  state_t state, state_nx;

  logic                  last_grant;
  logic                  id_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic gnt0, gnt1;
  logic acc, acc_id, acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = req0_valid & (~req1_valid | last_grant);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = (state == IDLE) & gnt0;
  assign req1_ready = (state == IDLE) & gnt1;

  assign acc       = req0_ready | req1_ready;
  assign acc_id    = req1_ready;
  assign acc_we    = acc_id ? req1_we : req0_we;
  assign acc_addr  = acc_id ? req1_addr : req0_addr;
  assign acc_wdata = acc_id ? req1_wdata : req0_wdata;

  // Only the WR state may drive the shared bus.
  assign sram_data = (state == WR) ? wdata_q
                                   : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_nx  = state;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_oe   = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (acc) state_nx = acc_we ? WR : RD1;
      end
      WR: begin
        sram_cs  = 1'b1;
        sram_we  = 1'b1;
        state_nx = IDLE;
      end
      RD1: begin
        sram_cs  = 1'b1;
        state_nx = RD2;
      end
      RD2: begin
        sram_cs  = 1'b1;
        sram_oe  = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // sram_addr doubles as the latched address and holds between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      wdata_q    <= '0;
      sram_addr  <= '0;
    end else if (acc) begin
      last_grant <= acc_id;
      id_q       <= acc_id;
      wdata_q    <= acc_wdata;
      sram_addr  <= acc_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_id    <= 1'b0;
    end else if (state == RD2) begin
      rsp_rdata <= sram_data;
      rsp_id    <= id_q;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with an SRAM model and a transaction-level reference.
// Directed vectors: write/read, tie-break, fairness, bus ownership, mid-read reset, boundary addresses.
module tb_sram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic          req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          rsp_valid, rsp_id, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_cs, sram_we, sram_oe;
  wire  [DW-1:0] sram_data;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .busy(busy), .sram_addr(sram_addr),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_data(sram_data)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives on output-enable, writes on a write edge.
  logic [DW-1:0] mem [0:65535];
  logic          sram_drive;
  assign sram_drive = sram_cs && sram_oe && !sram_we;
  assign sram_data  = sram_drive ? mem[sram_addr] : {DW{1'bz}};

  initial forever begin
    @(posedge clk);
    if (sram_cs && sram_we) mem[sram_addr] <= sram_data;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct {
    logic          id;
    int            cyc;
    logic [DW-1:0] data;
  } ev_t;

  op_t q0[$];
  op_t q1[$];
  ev_t glog[$];
  ev_t rlog[$];
  logic [DW-1:0] ref_mem [int];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int k = 0;
  int gcnt0 = 0, gcnt1 = 0;

  logic          lg = 1'b1;
  op_t           cur;
  logic          cur_id = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] exp_rdata = '0;
  logic          g0, g1, wr, rd1, rd2, rs;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: a transaction occupies 1 cycle (write) or 3 cycles (read)
  // after the cycle in which it was accepted.
  initial forever begin
    @(negedge clk);
    if (busy) busy_cnt++;
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cs", 32'(sram_cs), 0);
      chk("rst_we", 32'(sram_we), 0);
      chk("rst_oe", 32'(sram_oe), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rdata", 32'(rsp_rdata), 0);
      chk("rst_addr", 32'(sram_addr), 0);
      k = 0;
      lg = 1'b1;
      last_addr = '0;
      exp_rdata = '0;
    end else begin
      g0  = (k == 0) && req0_valid && (!req1_valid || lg);
      g1  = (k == 0) && req1_valid && !g0;
      wr  = (k == 1) && cur.we;
      rd1 = (k == 1) && !cur.we;
      rd2 = (k == 2);
      rs  = (k == 3);
      if (rs) exp_rdata = ref_mem[int'(cur.addr)];
      chk("ready0", 32'(req0_ready), 32'(g0));
      chk("ready1", 32'(req1_ready), 32'(g1));
      chk("busy", 32'(busy), 32'(k != 0));
      chk("cs", 32'(sram_cs), 32'(wr || rd1 || rd2));
      chk("we", 32'(sram_we), 32'(wr));
      chk("oe", 32'(sram_oe), 32'(rd2));
      chk("rsp_valid", 32'(rsp_valid), 32'(rs));
      chk("sram_addr", 32'(sram_addr), 32'(last_addr));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
      if (wr) begin
        chk("wdata_bus", 32'(sram_data), 32'(cur.data));
        ref_mem[int'(cur.addr)] = cur.data;
      end
      if (rs) begin
        chk("rsp_id", 32'(rsp_id), 32'(cur_id));
        rlog.push_back('{rsp_id, cyc, rsp_rdata});
      end
      if (g0 || g1) begin
        cur = g0 ? q0[0] : q1[0];
        cur_id = g1;
        lg = g1;
        last_addr = cur.addr;
        if (g0) gcnt0++;
        else gcnt1++;
        glog.push_back('{g1, cyc, cur.data});
        k = 1;
      end else if ((k == 1 && cur.we) || k == 3) begin
        k = 0;
      end else if (k != 0) begin
        k++;
      end
    end
  end

  int pop0 = 0, pop1 = 0;

  task automatic drive();
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    req0_we    = req0_valid ? q0[0].we : 1'b0;
    req0_addr  = req0_valid ? q0[0].addr : '0;
    req0_wdata = req0_valid ? q0[0].data : '0;
    req1_we    = req1_valid ? q1[0].we : 1'b0;
    req1_addr  = req1_valid ? q1[0].addr : '0;
    req1_wdata = req1_valid ? q1[0].data : '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (pop0 < gcnt0) begin
      q0.delete(0);
      pop0++;
    end
    while (pop1 < gcnt1) begin
      q1.delete(0);
      pop1++;
    end
    drive();
  endtask

  task automatic run();
    int n;
    n = 0;
    drive();
    while ((q0.size() != 0 || q1.size() != 0 || k != 0) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL run_timeout: got %0d cycles expected <300", n);
      q0.delete();
      q1.delete();
    end
    step();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int b0, gs, rs0, c0, c1, n;

  initial begin
    rst_n = 1'b0;
    drive();
    repeat (3) @(negedge clk);
    chk("reset_addr_lit", 32'(sram_addr), 0);
    chk("reset_rdata_lit", 32'(rsp_rdata), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single write then read
    q0.push_back('{1'b1, 16'h0010, 8'hA5});
    run();
    q0.push_back('{1'b0, 16'h0010, 8'h00});
    run();
    chk("t1_nrsp", 32'(rlog.size()), 1);
    chk("t1_rdata", 32'(rlog[$].data), 32'h A5);
    chk("t1_id", 32'(rlog[$].id), 0);
    chk("t1_latency", 32'(rlog[$].cyc - glog[$].cyc), 3);

    // simultaneous writes right after reset: req0 first
    reset_pulse();
    q0.push_back('{1'b1, 16'h0001, 8'h11});
    q1.push_back('{1'b1, 16'h0002, 8'h22});
    run();
    n = glog.size();
    chk("t2_first", 32'(glog[n-2].id), 0);
    chk("t2_second", 32'(glog[n-1].id), 1);
    chk("t2_wr_spacing", 32'(glog[n-1].cyc - glog[n-2].cyc), 2);
    q0.push_back('{1'b0, 16'h0001, 8'h00});
    q1.push_back('{1'b0, 16'h0002, 8'h00});
    run();
    n = rlog.size();
    chk("t2_rd0_id", 32'(rlog[n-2].id), 0);
    chk("t2_rd0", 32'(rlog[n-2].data), 32'h11);
    chk("t2_rd1_id", 32'(rlog[n-1].id), 1);
    chk("t2_rd1", 32'(rlog[n-1].data), 32'h22);

    // fairness: 8 competing reads alternate
    gs = glog.size();
    rs0 = rlog.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, (i % 2 == 0) ? 16'h0010 : 16'h0001, 8'h00});
      q1.push_back('{1'b0, 16'h0002, 8'h00});
    end
    run();
    chk("t3_ngrants", 32'(glog.size() - gs), 8);
    for (int i = 0; i < 8; i++) begin
      if (gs + i < glog.size()) begin
        chk("t3_alt", 32'(glog[gs+i].id), 32'(i % 2));
        if (i > 0)
          chk("t3_rd_spacing",
              32'(glog[gs+i].cyc - glog[gs+i-1].cyc), 4);
      end
    end
    c0 = 0;
    c1 = 0;
    for (int i = rs0; i < rlog.size(); i++) begin
      if (rlog[i].id) c1++;
      else c0++;
    end
    chk("t3_rsp0", 32'(c0), 4);
    chk("t3_rsp1", 32'(c1), 4);

    // write -> read -> write on the shared bus
    q0.push_back('{1'b1, 16'h0020, 8'h3C});
    q0.push_back('{1'b0, 16'h0020, 8'h00});
    q0.push_back('{1'b1, 16'h0021, 8'h96});
    run();
    chk("t4_rdata", 32'(rlog[$].data), 32'h3C);

    // reset in the middle of a read
    rs0 = rlog.size();
    q0.push_back('{1'b0, 16'h0010, 8'h00});
    drive();
    n = 0;
    while (k != 2 && n < 20) begin
      step();
      n++;
    end
    chk("t5_reach_rd2", 32'(k), 2);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_cs", 32'(sram_cs), 0);
    chk("t5_we", 32'(sram_we), 0);
    chk("t5_oe", 32'(sram_oe), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("t5_no_rsp", 32'(rlog.size()), 32'(rs0));
    q0.push_back('{1'b0, 16'h0010, 8'h00});
    run();
    chk("t5_rdata", 32'(rlog[$].data), 32'h A5);

    // boundary addresses and busy accounting
    b0 = busy_cnt;
    q0.push_back('{1'b1, 16'h0000, 8'h5A});
    q0.push_back('{1'b1, 16'hFFFF, 8'hC3});
    q0.push_back('{1'b0, 16'h0000, 8'h00});
    q0.push_back('{1'b0, 16'hFFFF, 8'h00});
    run();
    chk("t6_busy_cycles", 32'(busy_cnt - b0), 8);
    n = rlog.size();
    chk("t6_rd_lo", 32'(rlog[n-2].data), 32'h5A);
    chk("t6_rd_hi", 32'(rlog[n-1].data), 32'hC3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
